// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel runtime-programmable clock divider.
// Each channel divides clk by 2*D, producing a 50% square wave (clk_out)
// and a one-cycle tick coincident with every clk_out change. New divisors
// are staged in a pending register and applied at the channel's next
// half-period boundary, so the output never glitches.
// Optional feature: define CLKDIV_SYNC_EN to add the sync port, which
// realigns every channel (and applies pending divisors) in one cycle.
module prog_clk_divider #(
   parameter int N_CH    = 4,
   parameter int W       = 27,
   parameter int DEF_DIV = 50000000,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] en,
   input  logic            wr_en,
   input  logic [CH_W-1:0] wr_ch,
   input  logic [W-1:0]    wr_div,
`ifdef CLKDIV_SYNC_EN
   input  logic            sync,
`endif
   output logic [N_CH-1:0] clk_out,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] pending
);

   localparam logic [W-1:0] DEF_D = W'(DEF_DIV);

   logic sync_req;

   // Global realign request; tied off when the sync feature is not built.
`ifdef CLKDIV_SYNC_EN
   assign sync_req = sync;
`else
   assign sync_req = 1'b0;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [W-1:0] cnt;
      logic [W-1:0] div;
      logic [W-1:0] pdiv;
      logic         co_r;
      logic         tk_r;
      logic         pd_r;
      logic         wr_hit;
      logic         have_new;
      logic [W-1:0] new_div;
      logic         stopped;
      logic         wrap;

      // Decode this channel's write and pick the divisor to apply: a write in
      // the current cycle bypasses the pending register (last write wins).
      // Channel indices at or above N_CH never match any channel.
      always_comb begin
         wr_hit   = wr_en && (wr_ch == CH_W'(i));
         have_new = wr_hit || pd_r;
         new_div  = wr_hit ? wr_div : pdiv;
         stopped  = (div == '0) || !en[i];
         wrap     = (cnt == (div - 1'b1));
      end

      // Per-channel counter, output toggle, tick and divisor update.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt  <= '0;
            co_r <= 1'b0;
            tk_r <= 1'b0;
            div  <= DEF_D;
            pdiv <= '0;
            pd_r <= 1'b0;
         end else if (sync_req) begin
            // Realign: restart the half-period from zero on every channel.
            cnt  <= '0;
            co_r <= 1'b0;
            tk_r <= 1'b0;
            if (have_new) begin
               div  <= new_div;
               pd_r <= 1'b0;
            end
         end else if (stopped) begin
            // Idle or disabled: no boundary to wait for, so apply at once.
            tk_r <= 1'b0;
            if (have_new) begin
               div  <= new_div;
               pd_r <= 1'b0;
               cnt  <= '0;
            end else if (div == '0) begin
               cnt  <= '0;
               co_r <= 1'b0;
            end
         end else if (wrap) begin
            // Half-period boundary: toggle with the old divisor, then switch.
            cnt  <= '0;
            co_r <= ~co_r;
            tk_r <= 1'b1;
            if (have_new) begin
               div  <= new_div;
               pd_r <= 1'b0;
            end
         end else begin
            cnt  <= cnt + 1'b1;
            tk_r <= 1'b0;
            if (wr_hit) begin
               pdiv <= wr_div;
               pd_r <= 1'b1;
            end
         end
      end

      assign clk_out[i] = co_r;
      assign tick[i]    = tk_r;
      assign pending[i] = pd_r;
   end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Testbench for prog_clk_divider with N_CH=2, W=8, DEF_DIV=3.
// Expected outputs for each clock edge are derived arithmetically from the
// scenario, queued as the stimulus for that edge is driven, and popped for
// comparison after the edge. Define CLKDIV_SYNC_EN to include the sync test.
module tb_prog_clk_divider;
   localparam int N_CH    = 2;
   localparam int W       = 8;
   localparam int DEF_DIV = 3;

   typedef struct packed {
      logic [1:0] co;
      logic [1:0] tk;
      logic [1:0] pd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] en = 2'b00;
   logic       wr_en = 1'b0;
   logic [0:0] wr_ch = 1'b0;
   logic [7:0] wr_div = 8'd0;
`ifdef CLKDIV_SYNC_EN
   logic       sync = 1'b0;
`endif
   logic [1:0] clk_out;
   logic [1:0] tick;
   logic [1:0] pending;

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   prog_clk_divider #(.N_CH(N_CH), .W(W), .DEF_DIV(DEF_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .wr_en(wr_en),
      .wr_ch(wr_ch),
      .wr_div(wr_div),
`ifdef CLKDIV_SYNC_EN
      .sync(sync),
`endif
      .clk_out(clk_out),
      .tick(tick),
      .pending(pending)
   );

   // Square wave level after kk counting edges with a constant divisor d.
   function automatic logic lvl(input int kk, input int d);
      return ((kk / d) % 2) != 0;
   endfunction

   // Tick after kk counting edges with a constant divisor d.
   function automatic logic tk_at(input int kk, input int d);
      return (kk > 0) && ((kk % d) == 0);
   endfunction

   task automatic do_reset();
      en     = 2'b00;
      wr_en  = 1'b0;
      wr_ch  = 1'b0;
      wr_div = 8'd0;
`ifdef CLKDIV_SYNC_EN
      sync   = 1'b0;
`endif
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         en    = 2'b11;
         e.co  = {lvl(k, 3), lvl(k, 3)};
         e.tk  = {tk_at(k, 3), tk_at(k, 3)};
         e.pd  = 2'b00;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL basic k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
   endtask

   task automatic test_write();
      logic c0, t0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         en     = 2'b11;
         wr_en  = (k == 2);
         wr_ch  = 1'b0;
         wr_div = 8'd5;
         c0 = (k < 3) ? 1'b0 : (((1 + (k - 3) / 5) % 2) != 0);
         t0 = (k >= 3) && (((k - 3) % 5) == 0);
         e.co = {lvl(k, 3), c0};
         e.tk = {tk_at(k, 3), t0};
         e.pd = {1'b0, (k == 2)};
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL write k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_last_write();
      logic c0, t0, c1, t1;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         en    = 2'b11;
         wr_en = (k <= 3);
         case (k)
            1:       begin wr_ch = 1'b1; wr_div = 8'd7; end
            2:       begin wr_ch = 1'b1; wr_div = 8'd2; end
            default: begin wr_ch = 1'b0; wr_div = 8'd4; end
         endcase
         // ch0: written 4 on its wrap edge (3), so half-periods of 4 follow
         c0 = (k < 3) ? 1'b0 : (((1 + (k - 3) / 4) % 2) != 0);
         t0 = (k >= 3) && (((k - 3) % 4) == 0);
         // ch1: 7 then 2 written before the wrap at 3; only 2 takes effect
         c1 = (k < 3) ? 1'b0 : (((1 + (k - 3) / 2) % 2) != 0);
         t1 = (k >= 3) && (((k - 3) % 2) == 0);
         e.co = {c1, c0};
         e.tk = {t1, t0};
         e.pd = {(k == 1 || k == 2), 1'b0};
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL last_write k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_stop();
      logic c0, t0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         en     = 2'b11;
         wr_ch  = 1'b0;
         wr_en  = (k == 1) || (k == 6);
         wr_div = (k == 1) ? 8'd0 : 8'd4;
         if (k < 3) begin
            c0 = 1'b0; t0 = 1'b0;
         end else if (k == 3) begin
            c0 = 1'b1; t0 = 1'b1;
         end else if (k < 10) begin
            c0 = 1'b0; t0 = 1'b0;
         end else begin
            c0 = (((k - 10) / 4) % 2) == 0;
            t0 = ((k - 10) % 4) == 0;
         end
         e.co = {lvl(k, 3), c0};
         e.tk = {tk_at(k, 3), t0};
         e.pd = {1'b0, (k == 1 || k == 2)};
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL stop k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_enable();
      int kk;
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         en = (k >= 5 && k <= 14) ? 2'b10 : 2'b11;
         kk = (k <= 4) ? k : ((k <= 14) ? 4 : k - 10);
         e.co = {lvl(k, 3), lvl(kk, 3)};
         e.tk = {tk_at(k, 3), (k <= 4 || k > 14) && tk_at(kk, 3)};
         e.pd = 2'b00;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL enable k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
   endtask

   task automatic test_reset();
      // Asynchronous reset value before any clock edge in this test
      #2;
      rst = 1'b1;
      #1;
      e = '0;
      sb.push_back(e);
      e = sb.pop_front();
      n_chk++;
      if ({clk_out, tick, pending} !== e) begin
         n_fail++;
         $display("FAIL reset_initial: got co=%b tk=%b pd=%b, want all zero",
                  clk_out, tick, pending);
      end
      do_reset();
      // Run into the second half-period with a write pending on ch1
      for (int k = 1; k <= 4; k++) begin
         en     = 2'b11;
         wr_en  = (k == 4);
         wr_ch  = 1'b1;
         wr_div = 8'd7;
         e.co = {lvl(k, 3), lvl(k, 3)};
         e.tk = {tk_at(k, 3), tk_at(k, 3)};
         e.pd = {(k == 4), 1'b0};
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL reset_pre k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
      wr_en = 1'b0;
      // Mid-cycle assertion must clear outputs without waiting for an edge
      #2;
      rst = 1'b1;
      #1;
      e = '0;
      sb.push_back(e);
      e = sb.pop_front();
      n_chk++;
      if ({clk_out, tick, pending} !== e) begin
         n_fail++;
         $display("FAIL reset_async: got co=%b tk=%b pd=%b, want all zero",
                  clk_out, tick, pending);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Default divisor restored and the pending write discarded
      for (int k = 1; k <= 9; k++) begin
         en   = 2'b11;
         e.co = {lvl(k, 3), lvl(k, 3)};
         e.tk = {tk_at(k, 3), tk_at(k, 3)};
         e.pd = 2'b00;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL reset_post k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
   endtask

`ifdef CLKDIV_SYNC_EN
   task automatic test_sync();
      int k0, k1;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         en     = (k == 1) ? 2'b10 : 2'b11;
         sync   = (k == 5);
         wr_en  = (k == 5);
         wr_ch  = 1'b1;
         wr_div = 8'd3;
         if (k < 5) begin
            k0 = k - 1;
            k1 = k;
         end else begin
            k0 = k - 5;
            k1 = k - 5;
         end
         e.co = {lvl(k1, 3), lvl(k0, 3)};
         e.tk = {tk_at(k1, 3), tk_at(k0, 3)};
         e.pd = 2'b00;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_chk++;
         if ({clk_out, tick, pending} !== e) begin
            n_fail++;
            $display("FAIL sync k=%0d: got co=%b tk=%b pd=%b, want co=%b tk=%b pd=%b",
                     k, clk_out, tick, pending, e.co, e.tk, e.pd);
         end
      end
      sync  = 1'b0;
      wr_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_write();
      test_last_write();
      test_stop();
      test_enable();
`ifdef CLKDIV_SYNC_EN
      test_sync();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
